// File: rtl/cic_comb_decimator.sv
// cic_comb_decimator: decimation and comb section of a CIC decimator.
//
// It takes the full-rate, wrapped output of the integrator cascade and keeps
// one sample every R enabled clocks. Each kept sample goes through STAGES
// pipelined comb stages with differential delay DIFF_DELAY, then through an
// output quantiser that either rounds and saturates or truncates. The output
// has a one-cycle valid strobe.
//
// Ports:
//   clk      system clock
//   rst_n    synchronous active-low reset
//   en       input qualifier; x is a valid sample when en=1
//   x        integrator output, two's complement, wraps mod 2^DATA_WIDTH
//   rate     decimation ratio R (0 behaves as 1), taken at frame boundaries
//   y        decimated, quantised output (holds between strobes)
//   y_valid  one-cycle strobe marking a new y (held low during warm-up)

// One comb stage: out = in - in delayed by M strobes. The delay line moves
// only on the stage strobe, so idle cycles never age the history.
module cic_comb_stage #(
  parameter int DW = 12,
  parameter int M  = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          v_i,
  input  logic [DW-1:0] d_i,
  output logic          v_o,
  output logic [DW-1:0] d_o
);
  logic          v_q;
  logic [DW-1:0] d_q;
  logic [DW-1:0] z_q [M];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q <= 1'b0;
      d_q <= '0;
      for (int m = 0; m < M; m++) z_q[m] <= '0;
    end else begin
      v_q <= v_i;
      if (v_i) begin
        // Modular subtraction. Integrator wrap-around cancels out here.
        d_q    <= d_i - z_q[M-1];
        z_q[0] <= d_i;
        for (int m = 1; m < M; m++) z_q[m] <= z_q[m-1];
      end
    end
  end

  assign v_o = v_q;
  assign d_o = d_q;
endmodule

module cic_comb_decimator #(
  parameter int DATA_WIDTH = 12,
  parameter int OUT_WIDTH  = 12,
  parameter int STAGES     = 3,
  parameter int DIFF_DELAY = 1,
  parameter int RATE_WIDTH = 8,
  parameter int ROUND      = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] x,
  input  logic [RATE_WIDTH-1:0] rate,
  output logic [OUT_WIDTH-1:0]  y,
  output logic                  y_valid
);
  localparam int SH   = DATA_WIDTH - OUT_WIDTH;
  localparam int WARM = STAGES * DIFF_DELAY;
  localparam int WW   = $clog2(WARM + 1);

  logic [RATE_WIDTH-1:0] cnt_q, rate_q, rate_eff;
  logic                  cap;
  logic [DATA_WIDTH-1:0] d0_q;
  logic                  v0_q;

  // Element 0 is the decimated sample. Element i is the output of comb stage i.
  logic [DATA_WIDTH-1:0] d_w [STAGES+1];
  logic [STAGES:0]       v_w;

  logic [OUT_WIDTH-1:0]  q_w;
  logic [OUT_WIDTH-1:0]  y_q;
  logic                  y_valid_q;
  logic [WW-1:0]         warm_q;

  assign rate_eff = (rate == '0) ? RATE_WIDTH'(1) : rate;
  assign cap      = en && (cnt_q == rate_q - RATE_WIDTH'(1));

  // Decimator. rate is sampled only at capture edges, so a frame that is
  // already running always finishes at the ratio it started with.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      rate_q <= rate_eff;
      d0_q   <= '0;
      v0_q   <= 1'b0;
    end else begin
      v0_q <= cap;
      if (cap) begin
        cnt_q  <= '0;
        rate_q <= rate_eff;
        d0_q   <= x;
      end else if (en) begin
        cnt_q  <= cnt_q + RATE_WIDTH'(1);
      end
    end
  end

  assign d_w[0] = d0_q;
  assign v_w[0] = v0_q;

  for (genvar i = 1; i <= STAGES; i++) begin : g_comb
    cic_comb_stage #(.DW(DATA_WIDTH), .M(DIFF_DELAY)) u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .v_i   (v_w[i-1]),
      .d_i   (d_w[i-1]),
      .v_o   (v_w[i]),
      .d_o   (d_w[i])
    );
  end

  // Output quantiser
  if (SH == 0) begin : g_pass
    assign q_w = d_w[STAGES];
  end else if (ROUND == 0) begin : g_trunc
    assign q_w = OUT_WIDTH'(d_w[STAGES] >> SH);
  end else begin : g_round
    localparam logic [DATA_WIDTH-1:0] HALF = DATA_WIDTH'(1) << (SH - 1);
    logic [DATA_WIDTH-1:0] sum;
    logic                  ovf;
    assign sum = d_w[STAGES] + HALF;
    // Adding +half can only overflow upward: a positive input turns negative.
    assign ovf = ~d_w[STAGES][DATA_WIDTH-1] & sum[DATA_WIDTH-1];
    assign q_w = ovf ? {1'b0, {(OUT_WIDTH-1){1'b1}}} : OUT_WIDTH'(sum >> SH);
  end

  // Output register. y follows every comb result, but the strobe stays low
  // until the delay lines hold real history (N*M outputs after reset).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_q       <= '0;
      y_valid_q <= 1'b0;
      warm_q    <= '0;
    end else begin
      y_valid_q <= v_w[STAGES] && (warm_q == WW'(WARM));
      if (v_w[STAGES]) begin
        y_q <= q_w;
        if (warm_q != WW'(WARM)) warm_q <= warm_q + WW'(1);
      end
    end
  end

  assign y       = y_q;
  assign y_valid = y_valid_q;
endmodule

// File: tb/tb_cic_comb_decimator.sv
// Testbench for cic_comb_decimator. Five instances with different
// configurations share one stimulus stream. A reference model computes each
// output as the N-th order M-lag difference of the captured samples, using
// binomial coefficients, then applies the quantiser rule arithmetically.
module tb_cic_comb_decimator;
  localparam int ND = 5;
  localparam int CN  [ND] = '{1, 3, 1, 1, 2};
  localparam int CM  [ND] = '{1, 1, 1, 1, 2};
  localparam int CDW [ND] = '{12, 12, 16, 16, 16};
  localparam int CRND[ND] = '{1, 1, 1, 0, 1};

  logic        clk = 1'b0;
  logic        rst_n, en;
  logic [15:0] x;
  logic [7:0]  rate;
  logic [11:0] yo [ND];
  logic [ND-1:0] vo;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cic_comb_decimator #(.DATA_WIDTH(12), .OUT_WIDTH(12), .STAGES(1), .DIFF_DELAY(1), .RATE_WIDTH(8), .ROUND(1))
    u0 (.clk(clk), .rst_n(rst_n), .en(en), .x(x[11:0]), .rate(rate), .y(yo[0]), .y_valid(vo[0]));
  cic_comb_decimator #(.DATA_WIDTH(12), .OUT_WIDTH(12), .STAGES(3), .DIFF_DELAY(1), .RATE_WIDTH(8), .ROUND(1))
    u1 (.clk(clk), .rst_n(rst_n), .en(en), .x(x[11:0]), .rate(rate), .y(yo[1]), .y_valid(vo[1]));
  cic_comb_decimator #(.DATA_WIDTH(16), .OUT_WIDTH(12), .STAGES(1), .DIFF_DELAY(1), .RATE_WIDTH(8), .ROUND(1))
    u2 (.clk(clk), .rst_n(rst_n), .en(en), .x(x), .rate(rate), .y(yo[2]), .y_valid(vo[2]));
  cic_comb_decimator #(.DATA_WIDTH(16), .OUT_WIDTH(12), .STAGES(1), .DIFF_DELAY(1), .RATE_WIDTH(8), .ROUND(0))
    u3 (.clk(clk), .rst_n(rst_n), .en(en), .x(x), .rate(rate), .y(yo[3]), .y_valid(vo[3]));
  cic_comb_decimator #(.DATA_WIDTH(16), .OUT_WIDTH(12), .STAGES(2), .DIFF_DELAY(2), .RATE_WIDTH(8), .ROUND(1))
    u4 (.clk(clk), .rst_n(rst_n), .en(en), .x(x), .rate(rate), .y(yo[4]), .y_valid(vo[4]));

  // ---------------- reference model ----------------
  typedef struct {int due; int d; logic [11:0] val; bit vld;} ev_t;
  ev_t         pend[$];
  logic [15:0] hist[$];
  logic [11:0] ey [ND];
  bit          ev [ND];
  int          edge_n = 0;
  int          cnt_m, rate_m;

  function automatic longint binom(int n, int k);
    longint r = 1;
    for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
    return r;
  endfunction

  // Output for the newest sample of hist, as seen by configuration d.
  function automatic logic [11:0] model_out(int d);
    int     n    = hist.size() - 1;
    longint mask = (longint'(1) << CDW[d]) - 1;
    longint acc  = 0;
    longint c, s;
    int     sh   = CDW[d] - 12;
    for (int j = 0; j <= CN[d]; j++) begin
      int idx = n - j * CM[d];
      if (idx >= 0)
        acc += ((j % 2) ? -binom(CN[d], j) : binom(CN[d], j)) * (longint'(hist[idx]) & mask);
    end
    c = acc & mask;
    if (sh == 0) return c[11:0];
    if (CRND[d] == 0) return 12'(c >> sh);
    s = (c >= (longint'(1) << (CDW[d] - 1))) ? c - (longint'(1) << CDW[d]) : c;
    s = (s + (longint'(1) << (sh - 1))) >>> sh;
    if (s > 2047) s = 2047;
    return 12'(s);
  endfunction

  always @(posedge clk) begin
    edge_n++;
    if (!rst_n) begin
      hist.delete();
      pend.delete();
      cnt_m  = 0;
      rate_m = (rate == 0) ? 1 : int'(rate);
      for (int d = 0; d < ND; d++) begin ey[d] = '0; ev[d] = 0; end
    end else begin
      for (int d = 0; d < ND; d++) ev[d] = 0;
      for (int k = pend.size() - 1; k >= 0; k--)
        if (pend[k].due == edge_n) begin
          ey[pend[k].d] = pend[k].val;
          ev[pend[k].d] = pend[k].vld;
          pend.delete(k);
        end
      if (en) begin
        if (cnt_m == rate_m - 1) begin
          hist.push_back(x);
          for (int d = 0; d < ND; d++)
            pend.push_back('{edge_n + CN[d] + 1, d, model_out(d),
                             (hist.size() - 1) >= CN[d] * CM[d]});
          cnt_m  = 0;
          rate_m = (rate == 0) ? 1 : int'(rate);
        end else begin
          cnt_m++;
        end
      end
    end
  end

  // ---------------- stimulus / checks ----------------
  task automatic do_reset(input int r);
    rate = 8'(r); en = 1'b0; x = '0; rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    int first = 0;
    rate = 8'd4; en = 1'b1; x = '0; rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
        n_cmp++;
        if (yo[d] !== 12'h000 || vo[d] !== 1'b0) begin
          n_bad++;
          $display("FAIL reset_state dut%0d: y=%h v=%b, want y=000 v=0", d, yo[d], vo[d]);
        end
      end
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
        n_cmp++;
        if (vo[d] !== ev[d] || yo[d] !== ey[d]) begin
          n_bad++;
          $display("FAIL warmup dut%0d @%0d: y=%h v=%b, want y=%h v=%b", d, k, yo[d], vo[d], ey[d], ev[d]);
        end
      end
      if (vo[0] && first == 0) first = k;
    end
    n_cmp++;
    if (first !== 10) begin
      n_bad++;
      $display("FAIL warmup_first_valid: got cycle %0d, want 10", first);
    end
  endtask

  task automatic test_ramp;
    int last = 0;
    do_reset(4);
    en = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      x = 16'((4070 + k) % 4096);
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
        n_cmp++;
        if (vo[d] !== ev[d] || yo[d] !== ey[d]) begin
          n_bad++;
          $display("FAIL ramp dut%0d @%0d: y=%h v=%b, want y=%h v=%b", d, k, yo[d], vo[d], ey[d], ev[d]);
        end
      end
      if (vo[0]) begin
        n_cmp++;
        if (yo[0] !== 12'd4) begin
          n_bad++;
          $display("FAIL ramp_value @%0d: y=%0d, want 4", k, yo[0]);
        end
        if (last != 0) begin
          n_cmp++;
          if (k - last !== 4) begin
            n_bad++;
            $display("FAIL ramp_spacing @%0d: gap=%0d, want 4", k, k - last);
          end
        end
        last = k;
      end
    end
  endtask

  // N=3 with a unit step at sample 4. The third difference of a step is
  // 1,-2,1, followed by zeros.
  task automatic test_latency;
    logic [11:0] exp_y;
    do_reset(1);
    en = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      x = (k - 1 >= 4) ? 16'd1 : 16'd0;
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
        n_cmp++;
        if (vo[d] !== ev[d] || yo[d] !== ey[d]) begin
          n_bad++;
          $display("FAIL latency dut%0d @%0d: y=%h v=%b, want y=%h v=%b", d, k, yo[d], vo[d], ey[d], ev[d]);
        end
      end
      n_cmp++;
      if (vo[1] !== (k >= 8)) begin
        n_bad++;
        $display("FAIL latency_valid @%0d: v=%b, want %b", k, vo[1], k >= 8);
      end
      if (k >= 9 && k <= 12) begin
        exp_y = (k == 9) ? 12'h001 : (k == 10) ? 12'hFFE : (k == 11) ? 12'h001 : 12'h000;
        n_cmp++;
        if (yo[1] !== exp_y) begin
          n_bad++;
          $display("FAIL step_response @%0d: y=%h, want %h", k, yo[1], exp_y);
        end
      end
    end
  endtask

  task automatic test_rate_change;
    do_reset(4);
    en = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      if (k == 3) rate = 8'd8;
      x = 16'($urandom);
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
        n_cmp++;
        if (vo[d] !== ev[d] || yo[d] !== ey[d]) begin
          n_bad++;
          $display("FAIL rate_change dut%0d @%0d: y=%h v=%b, want y=%h v=%b", d, k, yo[d], vo[d], ey[d], ev[d]);
        end
      end
      n_cmp++;
      if (vo[0] !== (k == 14 || k == 22 || k == 30)) begin
        n_bad++;
        $display("FAIL rate_change_strobe @%0d: v=%b", k, vo[0]);
      end
    end
    do_reset(2);
    for (int k = 1; k <= 30; k++) begin
      en = (k % 2 == 1);
      x = 16'($urandom);
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
        n_cmp++;
        if (vo[d] !== ev[d] || yo[d] !== ey[d]) begin
          n_bad++;
          $display("FAIL en_gaps dut%0d @%0d: y=%h v=%b, want y=%h v=%b", d, k, yo[d], vo[d], ey[d], ev[d]);
        end
      end
      n_cmp++;
      if (vo[0] !== (k >= 9 && (k - 9) % 4 == 0)) begin
        n_bad++;
        $display("FAIL en_gaps_strobe @%0d: v=%b", k, vo[0]);
      end
    end
  endtask

  // Successive differences are 0x7FF8, 0x0018 and 0xFFF7.
  task automatic test_quant;
    logic [15:0] xs [4] = '{16'h0000, 16'h7FF8, 16'h8010, 16'h8007};
    logic [11:0] er, et;
    do_reset(1);
    en = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      x = (k <= 4) ? xs[k-1] : 16'h8007;
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
        n_cmp++;
        if (vo[d] !== ev[d] || yo[d] !== ey[d]) begin
          n_bad++;
          $display("FAIL quant dut%0d @%0d: y=%h v=%b, want y=%h v=%b", d, k, yo[d], vo[d], ey[d], ev[d]);
        end
      end
      if (k >= 4 && k <= 6) begin
        er = (k == 4) ? 12'h7FF : (k == 5) ? 12'h002 : 12'hFFF;
        et = (k == 4) ? 12'h7FF : (k == 5) ? 12'h001 : 12'hFFF;
        n_cmp += 2;
        if (yo[2] !== er || vo[2] !== 1'b1) begin
          n_bad++;
          $display("FAIL quant_round @%0d: y=%h v=%b, want %h v=1", k, yo[2], vo[2], er);
        end
        if (yo[3] !== et) begin
          n_bad++;
          $display("FAIL quant_trunc @%0d: y=%h, want %h", k, yo[3], et);
        end
      end
    end
  endtask

  task automatic test_midrun_reset;
    int first = 0;
    do_reset(4);
    en = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      x = 16'((100 + k) % 4096);
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
        n_cmp++;
        if (vo[d] !== ev[d] || yo[d] !== ey[d]) begin
          n_bad++;
          $display("FAIL midrun_pre dut%0d @%0d: y=%h v=%b, want y=%h v=%b", d, k, yo[d], vo[d], ey[d], ev[d]);
        end
      end
    end
    // A valid strobe would otherwise appear on this edge.
    rst_n = 1'b0;
    x = 16'd114;
    @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      n_cmp++;
      if (vo[d] !== 1'b0 || yo[d] !== 12'h000) begin
        n_bad++;
        $display("FAIL midrun_reset dut%0d: y=%h v=%b, want y=000 v=0", d, yo[d], vo[d]);
      end
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      x = 16'((4090 + k) % 4096);
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
        n_cmp++;
        if (vo[d] !== ev[d] || yo[d] !== ey[d]) begin
          n_bad++;
          $display("FAIL midrun_post dut%0d @%0d: y=%h v=%b, want y=%h v=%b", d, k, yo[d], vo[d], ey[d], ev[d]);
        end
      end
      if (vo[0] && first == 0) begin
        first = k;
        n_cmp++;
        if (yo[0] !== 12'd4) begin
          n_bad++;
          $display("FAIL midrun_value: y=%0d, want 4", yo[0]);
        end
      end
    end
    n_cmp++;
    if (first !== 10) begin
      n_bad++;
      $display("FAIL midrun_first_valid: got cycle %0d, want 10", first);
    end
  endtask

  task automatic test_random;
    do_reset(3);
    for (int k = 1; k <= 600; k++) begin
      en    = ($urandom_range(9) < 7);
      x     = 16'($urandom);
      if ($urandom_range(49) == 0) rate = 8'($urandom_range(5));
      rst_n = ($urandom_range(199) != 0);
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
        n_cmp++;
        if (vo[d] !== ev[d] || yo[d] !== ey[d]) begin
          n_bad++;
          $display("FAIL random dut%0d @%0d: y=%h v=%b, want y=%h v=%b", d, k, yo[d], vo[d], ey[d], ev[d]);
        end
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_latency();
    test_rate_change();
    test_quant();
    test_midrun_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
